// File: rtl/fifo_rd_packer.sv
// Packs bytes read from a registered-output FIFO into LANES-wide words with a
// per-lane keep mask. A flush drains the in-flight read and then emits any partial word.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4
) (
   input  logic                          clk_r,
   input  logic                          rst,
   input  logic                          fifo_empty,
   output logic                          fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]         fifo_data,
   input  logic                          flush,
   output logic                          flush_done,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [DATA_WIDTH*LANES-1:0]   m_data,
   output logic [LANES-1:0]              m_keep
);

   localparam int CW = $clog2(LANES) + 1;
   localparam int WW = DATA_WIDTH * LANES;
   localparam logic [CW-1:0] FULL = CW'(LANES);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      F_DRAIN = 2'd1,
      F_EMIT  = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    lane_cnt;
   logic             rd_pend;
   logic [WW-1:0]    asm_q;

   logic [CW:0]      occ;
   logic [WW-1:0]    asm_wr;
   logic [CW-1:0]    cnt_wr;
   logic [LANES-1:0] part_keep;
   logic             slot_free;
   logic             word_full;

   // Bytes held plus the one still in flight must leave room for another read.
   assign occ        = {1'b0, lane_cnt} + {{CW{1'b0}}, rd_pend};
   assign fifo_rd_en = !rst && !fifo_empty && (state == RUN) && (occ < {1'b0, FULL});
   assign slot_free  = !m_valid || m_ready;

   always_comb begin
      asm_wr    = asm_q;
      cnt_wr    = lane_cnt;
      part_keep = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (rd_pend && (lane_cnt == CW'(i)))
            asm_wr[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
         if (CW'(i) < lane_cnt)
            part_keep[i] = 1'b1;
      end
      if (rd_pend)
         cnt_wr = lane_cnt + CW'(1);
   end

   assign word_full = (cnt_wr == FULL);

   always_ff @(posedge clk_r or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         lane_cnt   <= '0;
         rd_pend    <= 1'b0;
         asm_q      <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_keep     <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         rd_pend    <= fifo_rd_en;
         asm_q      <= asm_wr;
         lane_cnt   <= cnt_wr;

         if (m_valid && m_ready)
            m_valid <= 1'b0;

         // A load overrides the transfer clear, so back-to-back words keep m_valid high.
         if (word_full && slot_free) begin
            m_valid  <= 1'b1;
            m_data   <= asm_wr;
            m_keep   <= '1;
            asm_q    <= '0;
            lane_cnt <= '0;
         end else if ((state == F_EMIT) && slot_free) begin
            m_valid  <= 1'b1;
            m_data   <= asm_q;
            m_keep   <= part_keep;
            asm_q    <= '0;
            lane_cnt <= '0;
         end

         case (state)
            RUN: begin
               if (flush)
                  state <= F_DRAIN;
            end
            F_DRAIN: begin
               // A full held word leaves via the normal path; lane_cnt then reads zero.
               if (!rd_pend) begin
                  if (lane_cnt == '0) begin
                     state      <= RUN;
                     flush_done <= 1'b1;
                  end else if (lane_cnt != FULL) begin
                     state <= F_EMIT;
                  end
               end
            end
            F_EMIT: begin
               if (slot_free) begin
                  state      <= RUN;
                  flush_done <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
